// File: rtl/remap_pipe.sv
// remap_pipe: two-stage leading-one remapper.
// Each accepted word becomes {leading-one index, optional normalised fraction}.
// Stage 1 locates the leading one. Stage 2 normalises the word and packs the result.
//
// Handshake (both ports):
//   - A transfer happens on a rising edge where valid && ready.
//   - Once a result is valid, the producer holds it, and it does not drop, until the transfer occurs.
//   - num_ready_o depends only on the stage valids and rslt_ready_i. It never depends on num_valid_i.
module remap_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             num_valid_i,
  output logic             num_ready_o,
  input  logic [WIDTH-1:0] num_i,
  input  logic             frac_en_i,
  output logic             rslt_valid_o,
  input  logic             rslt_ready_i,
  output logic [WIDTH-1:0] rslt_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int IDXW  = $clog2(WIDTH);
  localparam int FRACW = WIDTH - IDXW;

  // Stage 1 state
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic             frac_en1_q, frac_en1_d;
  logic [IDXW-1:0]  idx1_q, idx1_d;
  logic             zero1_q, zero1_d;

  // Stage 2 state
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] rslt2_q, rslt2_d;
  logic             zero2_q, zero2_d;

  logic             en1, en2;
  logic [IDXW-1:0]  lead_idx;
  logic [IDXW-1:0]  shamt;
  logic [WIDTH-1:0] shifted;
  logic [FRACW-1:0] frac;
  logic             unused_shift_bits;

  // Stage enables: a stage may load when it is empty or its contents move on.
  always_comb begin
    en2 = !v2_q || rslt_ready_i;
    en1 = !v1_q || en2;
  end

  // Priority encoder: the index of the highest set bit of the incoming word.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (num_i[i]) lead_idx = IDXW'(i);
    end
  end

  // Stage 1 next state.
  // Bubbles load as v1 = 0.
  // Data loads only on an accepted input.
  always_comb begin
    v1_d       = v1_q;
    num1_d     = num1_q;
    frac_en1_d = frac_en1_q;
    idx1_d     = idx1_q;
    zero1_d    = zero1_q;
    if (en1) begin
      v1_d = num_valid_i;
      if (num_valid_i) begin
        num1_d     = num_i;
        frac_en1_d = frac_en_i;
        idx1_d     = lead_idx;
        zero1_d    = (num_i == '0);
      end
    end
  end

  // Normalisation.
  // The shift moves the leading one to the MSB.
  // The fraction field is the bits just below the leading one, left-aligned.
  always_comb begin
    shamt   = IDXW'(WIDTH - 1) - idx1_q;
    shifted = num1_q << shamt;
    frac    = shifted[WIDTH-2 -: FRACW];
  end

  // The MSB is always the leading one.
  // The lowest bits fall off the truncated fraction field.
  assign unused_shift_bits = ^{shifted[WIDTH-1], shifted[IDXW-2:0]};

  // Stage 2 next state.
  // Pack {idx, frac}.
  // A zero operand yields an all-zero result with the flag set.
  always_comb begin
    v2_d    = v2_q;
    rslt2_d = rslt2_q;
    zero2_d = zero2_q;
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        if (zero1_q) begin
          rslt2_d = '0;
          zero2_d = 1'b1;
        end else begin
          rslt2_d = {idx1_q, (frac_en1_q ? frac : {FRACW{1'b0}})};
          zero2_d = 1'b0;
        end
      end
    end
  end

  // Pipeline registers. Reset empties both stages and clears all data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q       <= 1'b0;
      num1_q     <= '0;
      frac_en1_q <= 1'b0;
      idx1_q     <= '0;
      zero1_q    <= 1'b0;
      v2_q       <= 1'b0;
      rslt2_q    <= '0;
      zero2_q    <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      num1_q     <= num1_d;
      frac_en1_q <= frac_en1_d;
      idx1_q     <= idx1_d;
      zero1_q    <= zero1_d;
      v2_q       <= v2_d;
      rslt2_q    <= rslt2_d;
      zero2_q    <= zero2_d;
    end
  end

  assign num_ready_o  = en1;
  assign rslt_valid_o = v2_q;
  assign rslt_o       = rslt2_q;
  assign zero_o       = zero2_q;
  assign busy_o       = v1_q | v2_q;

endmodule

// File: tb/tb_remap_pipe.sv
// Testbench for remap_pipe.
// Three instances are built, at WIDTH 32, 8 and 64.
// Expected results come from an arithmetic description of the leading-one remap.
module tb_remap_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Index 0 is the WIDTH=32 instance, index 1 is WIDTH=8, index 2 is WIDTH=64.
  int          wd [3];
  logic        nv [3];
  logic        fe [3];
  logic        rr [3];
  logic [63:0] num[3];
  logic        rdy[3];
  logic        rv [3];
  logic        zo [3];
  logic        bsy[3];
  logic [63:0] rs [3];
  logic [31:0] r32;
  logic [7:0]  r8;
  logic [63:0] r64;

  always_comb begin
    rs[0] = {32'd0, r32};
    rs[1] = {56'd0, r8};
    rs[2] = r64;
  end

  remap_pipe #(.WIDTH(32)) u_w32 (
    .clk_i(clk), .rst_i(rst), .num_valid_i(nv[0]), .num_ready_o(rdy[0]),
    .num_i(num[0][31:0]), .frac_en_i(fe[0]), .rslt_valid_o(rv[0]),
    .rslt_ready_i(rr[0]), .rslt_o(r32), .zero_o(zo[0]), .busy_o(bsy[0]));

  remap_pipe #(.WIDTH(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .num_valid_i(nv[1]), .num_ready_o(rdy[1]),
    .num_i(num[1][7:0]), .frac_en_i(fe[1]), .rslt_valid_o(rv[1]),
    .rslt_ready_i(rr[1]), .rslt_o(r8), .zero_o(zo[1]), .busy_o(bsy[1]));

  remap_pipe #(.WIDTH(64)) u_w64 (
    .clk_i(clk), .rst_i(rst), .num_valid_i(nv[2]), .num_ready_o(rdy[2]),
    .num_i(num[2]), .frac_en_i(fe[2]), .rslt_valid_o(rv[2]),
    .rslt_ready_i(rr[2]), .rslt_o(r64), .zero_o(zo[2]), .busy_o(bsy[2]));

  // ---------------- reference model ----------------
  // Returns {zero_flag, result}.
  // idx is floor(log2(n)).
  // The fraction is n with its leading one removed, scaled so that it fills fw bits.
  function automatic logic [64:0] ref_model(input int w, input logic [63:0] n, input logic f);
    int iw, fw, idx;
    logic [63:0] rem, fr;
    if (n == 64'd0) return {1'b1, 64'd0};
    iw = 0;
    while ((1 << iw) < w) iw++;
    fw  = w - iw;
    idx = 0;
    for (int i = 0; i < w; i++) if (n[i]) idx = i;
    rem = n - (64'd1 << idx);
    if (fw >= idx) fr = rem << (fw - idx);
    else           fr = rem >> (idx - fw);
    if (!f) fr = 64'd0;
    return {1'b0, (64'(idx) << fw) | fr};
  endfunction

  function automatic logic [63:0] wmask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Random operand with a bias toward zero, single-bit and short values.
  function automatic logic [63:0] rand_num(input int w);
    int kind;
    kind = $urandom_range(0, 3);
    if (kind == 0) return 64'd0;
    if (kind == 1) return (64'd1 << $urandom_range(0, w - 1));
    return ({$urandom, $urandom} >> $urandom_range(0, 63)) & wmask(w);
  endfunction

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      nv[k]  = 1'b0;
      fe[k]  = 1'b0;
      rr[k]  = 1'b1;
      num[k] = 64'd0;
    end
  endtask

  // Send one word into an empty pipeline.
  // Waits, with a bound, for the result and returns it.
  task automatic run_one(input int sel, input logic [63:0] n, input logic f,
                         output logic [63:0] r, output logic z, output bit timeout);
    timeout = 1'b1;
    @(negedge clk);
    num[sel] = n;
    fe[sel]  = f;
    nv[sel]  = 1'b1;
    rr[sel]  = 1'b1;
    @(posedge clk);
    #1;
    nv[sel] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rv[sel]) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    r = rs[sel];
    z = zo[sel];
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    checks++;
    if ({rv[0], zo[0], bsy[0], rdy[0]} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags got={v,z,busy,rdy}=%b exp=0001", {rv[0], zo[0], bsy[0], rdy[0]});
    end
    checks++;
    if (rs[0] !== 64'd0) begin
      failures++;
      $display("FAIL reset_rslt got=%h exp=0", rs[0]);
    end

    // Load two entries while the output is stalled, then reset mid-cycle.
    rst = 1'b0;
    rr[0] = 1'b0;
    nv[0] = 1'b1;
    num[0] = 64'h5;
    @(negedge clk);
    num[0] = 64'h7;
    @(negedge clk);
    nv[0] = 1'b0;
    checks++;
    if (rv[0] !== 1'b1 || bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL fill_two got={v,busy,rdy}=%b exp=110", {rv[0], bsy[0], rdy[0]});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rv[0], zo[0], bsy[0], rdy[0]} !== 4'b0001 || rs[0] !== 64'd0) begin
      failures++;
      $display("FAIL midreset got={v,z,busy,rdy}=%b rslt=%h exp=0001 rslt=0",
               {rv[0], zo[0], bsy[0], rdy[0]}, rs[0]);
    end

    // Accept on the first edge after release.
    // The result must not be valid after the accept edge, and must be valid after the next edge.
    @(negedge clk);
    rst    = 1'b0;
    rr[0]  = 1'b1;
    nv[0]  = 1'b1;
    fe[0]  = 1'b1;
    num[0] = 64'hB0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL first_accept_ready got=%b exp=1", rdy[0]);
    end
    @(posedge clk);
    #1;
    nv[0] = 1'b0;
    checks++;
    if (rv[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=%b exp=0", rv[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rv[0] !== 1'b1 || rs[0] !== 64'h3B00_0000 || zo[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_b0 got v=%b rslt=%h z=%b exp v=1 rslt=3b000000 z=0", rv[0], rs[0], zo[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [31:0] tn [5];
    logic        tf [5];
    logic [31:0] te [5];
    logic        tz [5];
    logic [63:0] r;
    logic        z;
    bit          to;
    tn = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    tf = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    te = '{32'hFFFF_FFFF, 32'hF800_0000, 32'hF800_0000, 32'h0000_0000, 32'h0000_0000};
    tz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_one(0, {32'd0, tn[i]}, tf[i], r, z, to);
      checks++;
      if (to || r !== {32'd0, te[i]} || z !== tz[i]) begin
        failures++;
        $display("FAIL mode_%0d num=%h got=%h z=%b to=%b exp=%h z=%b", i, tn[i], r, z, to, te[i], tz[i]);
      end
    end
    // WIDTH=8 case.
    // 0x2D has its leading one at bit 5.
    // The bits below it, 01101, become the 5-bit fraction, so the result is {101, 01101}.
    run_one(1, 64'h2D, 1'b1, r, z, to);
    checks++;
    if (to || r !== 64'hAD || z !== 1'b0) begin
      failures++;
      $display("FAIL w8_2d got=%h z=%b to=%b exp=ad z=0", r, z, to);
    end
    // WIDTH=64 case: a single bit at position 40.
    run_one(2, 64'd1 << 40, 1'b1, r, z, to);
    checks++;
    if (to || r[63:58] !== 6'd40 || r[57:0] !== 58'd0) begin
      failures++;
      $display("FAIL w64_bit40 got=%h to=%b exp idx=40 frac=0", r, to);
    end
  endtask

  task automatic test_backpressure();
    int          acc;
    int          outs;
    logic [63:0] held;
    logic [64:0] e;
    exp_q.delete();
    acc = 0;
    @(negedge clk);
    rr[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      nv[0]  = 1'b1;
      num[0] = rand_num(32);
      fe[0]  = 1'($urandom_range(0, 1));
      #1;
      if (rdy[0]) begin
        acc++;
        exp_q.push_back(ref_model(32, num[0], fe[0]));
      end
      @(negedge clk);
    end
    nv[0] = 1'b0;
    checks++;
    if (acc !== 2 || rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepts got=%0d rdy=%b exp=2 rdy=0", acc, rdy[0]);
    end
    held = rs[0];
    repeat (3) @(negedge clk);
    checks++;
    if (rv[0] !== 1'b1 || rs[0] !== held) begin
      failures++;
      $display("FAIL bp_stable got v=%b rslt=%h exp v=1 rslt=%h", rv[0], rs[0], held);
    end
    rr[0] = 1'b1;
    outs = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rv[0]) begin
        outs++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        checks++;
        if ({zo[0], rs[0]} !== e) begin
          failures++;
          $display("FAIL bp_order got=%h exp=%h", {zo[0], rs[0]}, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (outs !== 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count got=%0d left=%0d exp=2 left=0", outs, exp_q.size());
    end
  endtask

  task automatic test_stream();
    int          outs;
    int          not_ready;
    logic [64:0] e;
    exp_q.delete();
    outs      = 0;
    not_ready = 0;
    rr[0]     = 1'b1;
    for (int i = 0; i < 64; i++) begin
      nv[0]  = 1'b1;
      num[0] = rand_num(32);
      fe[0]  = 1'($urandom_range(0, 1));
      #1;
      if (!rdy[0]) not_ready++;
      else exp_q.push_back(ref_model(32, num[0], fe[0]));
      if (rv[0]) begin
        outs++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        checks++;
        if ({zo[0], rs[0]} !== e) begin
          failures++;
          $display("FAIL stream_data got=%h exp=%h", {zo[0], rs[0]}, e);
        end
      end
      @(negedge clk);
    end
    nv[0] = 1'b0;
    // The last accept occurred at the edge just passed. Two more edges drain the pipeline.
    for (int c = 0; c < 2; c++) begin
      #1;
      if (rv[0]) begin
        outs++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        checks++;
        if ({zo[0], rs[0]} !== e) begin
          failures++;
          $display("FAIL stream_data got=%h exp=%h", {zo[0], rs[0]}, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (outs !== 64 || not_ready !== 0) begin
      failures++;
      $display("FAIL stream_rate got outs=%0d stalls=%0d exp outs=64 stalls=0", outs, not_ready);
    end
    checks++;
    if (bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL stream_busy got=%b exp=0", bsy[0]);
    end
  endtask

  task automatic test_random(input int sel, input int ncyc);
    int          w;
    bit          held;
    logic [63:0] hr;
    logic        hz;
    logic [64:0] e;
    w    = wd[sel];
    held = 1'b0;
    hr   = '0;
    hz   = 1'b0;
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (rv[sel] !== 1'b1 || rs[sel] !== hr || zo[sel] !== hz) begin
          failures++;
          $display("FAIL rnd%0d_hold got v=%b rslt=%h z=%b exp v=1 rslt=%h z=%b",
                   w, rv[sel], rs[sel], zo[sel], hr, hz);
        end
      end
      nv[sel]  = 1'($urandom_range(0, 1));
      num[sel] = rand_num(w);
      fe[sel]  = 1'($urandom_range(0, 1));
      rr[sel]  = ($urandom_range(0, 2) != 0);
      #1;
      if (nv[sel] && rdy[sel]) exp_q.push_back(ref_model(w, num[sel], fe[sel]));
      if (rv[sel] && rr[sel]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        checks++;
        if ({zo[sel], rs[sel]} !== e) begin
          failures++;
          $display("FAIL rnd%0d_data got=%h exp=%h", w, {zo[sel], rs[sel]}, e);
        end
      end
      held = rv[sel] && !rr[sel];
      hr   = rs[sel];
      hz   = zo[sel];
    end
    // Drain the pipeline.
    @(negedge clk);
    nv[sel] = 1'b0;
    rr[sel] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rv[sel]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        checks++;
        if ({zo[sel], rs[sel]} !== e) begin
          failures++;
          $display("FAIL rnd%0d_drain got=%h exp=%h", w, {zo[sel], rs[sel]}, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || bsy[sel] !== 1'b0) begin
      failures++;
      $display("FAIL rnd%0d_empty got left=%0d busy=%b exp left=0 busy=0", w, exp_q.size(), bsy[sel]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    wd[0] = 32;
    wd[1] = 8;
    wd[2] = 64;
    rst = 1'b1;
    idle_all();
    test_reset();
    test_modes();
    test_backpressure();
    test_stream();
    test_random(0, 10000);
    test_random(1, 3000);
    test_random(2, 3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
